vsq_quantizer: RTL and testbench
================================

VSQ_QUANTIZER -- requirements
Module: vsq_quantizer

Interface
REQ-001 SHALL have parameter NCH, default 16: channel (lane) count.
REQ-002 SHALL have parameter DW, default 40: signed input width per lane, fixed-point Q(DW-FRAC).FRAC.
REQ-003 SHALL have parameter FRAC, default 10: fractional bits of input and scale.
REQ-004 SHALL have parameter QBITS, default 4: signed output width per lane; QMAX = 2^(QBITS-1)-1.
REQ-005 SHALL have parameter DEPTH, default 64: vectors per block; AW = clog2(DEPTH).
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 Ports, in order:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  i_data is valid this cycle
- i_data  in  NCH*DW  post-ReLU vector, lane n at [n*DW +: DW]
- i_start  in  1  buffer filled; begin quantizing the block
- o_buf_addr  out  AW  buffer read address; sync read, data returns next cycle
- i_buf_data  in  NCH*DW  buffer read data
- o_ram_we  out  1  output write enable
- o_ram_addr  out  AW  output address
- o_ram_data  out  NCH*QBITS  quantized vector
- o_sf_valid  out  1  o_sf_data valid
- o_sf_data  out  NCH*DW  per-lane scale, Q.FRAC
- o_busy  out  1  in QUANT or FLUSH
- o_done  out  1  one-cycle pulse on final write

Function
REQ-008 SHALL implement states ACCUM (reset), QUANT and FLUSH.
REQ-009 In every state, i_valid=1 SHALL update run_max[n] = max(run_max[n], |lane n|).
REQ-010 |x| of the most-negative DW value SHALL saturate to 2^(DW-1)-1.
REQ-011 ACCUM with i_start=1 SHALL, in the same edge:
- copy run_max into snap_max;
- clear run_max, or load it with the current |i_data| if i_valid=1;
- enter QUANT with cnt=0.
REQ-012 i_start in QUANT or FLUSH SHALL be ignored.
REQ-013 QUANT SHALL drive o_buf_addr=cnt and increment cnt each cycle; at cnt=DEPTH-1 it SHALL enter FLUSH.
REQ-014 FLUSH SHALL last one cycle and then return to ACCUM.
REQ-015 Write timing:
- o_ram_we SHALL assert one cycle after each buffer address is issued;
- o_ram_addr SHALL equal that address.
REQ-016 Quantization, per lane, from the registered buffer data x and m = snap_max[n]:
- q = x*QMAX/m, clamped to [-QMAX, +QMAX];
- m = 0 SHALL give q = 0.
REQ-017 o_sf_data lane n SHALL be (snap_max[n]*RECIP) >> 16, with RECIP = round(2^16/QMAX).
- o_sf_valid SHALL equal o_ram_we.
REQ-018 o_done SHALL pulse on the write to address DEPTH-1.
REQ-019 o_busy SHALL be 1 in QUANT and FLUSH.
REQ-020 When not writing, o_ram_data and o_sf_data SHALL be 0.

Reset
REQ-021 i_rst SHALL clear run_max, snap_max, cnt and the pipeline registers, and force state ACCUM.
REQ-022 While reset is asserted, all outputs SHALL be 0, including o_buf_addr.
REQ-023 Reset mid-QUANT SHALL abort the block with no further writes.

Configuration
REQ-024 Macro VSQ_QUANT_ROUND_EN SHALL select the rounding of REQ-016:
- defined: round half away from zero;
- undefined: truncate toward zero.

Structure
REQ-025 Package vsq_pkg SHALL hold:
- state encoding;
- QMAX and RECIP functions of QBITS;
- the abs-saturate function.
REQ-026 Per-lane abs, max, divide, round and clamp SHALL live in sub-module vsq_lane_quant, instantiated NCH times by generate.

Verification
REQ-027 Defaults (QMAX=7):
- lane 0 max 7.0 (7168);
- buffer x = 3.0 (3072) -> q = 3;
- x = -7.0 -> q = -7 (4'b1001);
- sf = 1.0 (1023 with RECIP=9362; bench checks the exact formula).
REQ-028 Same max, x = 1.5 (1536):
- q = 2 with VSQ_QUANT_ROUND_EN;
- q = 1 without it.
REQ-029 Lane never fed (max 0), any x -> q = 0; sf = 0.
REQ-030 x = 20.0 with max 7.0 -> q clamps to +7.
- i_data lane = -2^39 -> run_max = 2^39-1.
REQ-031 Block timing:
- i_start at cycle T -> writes at T+2..T+65, addr 0..63;
- o_done at T+65; o_busy high T+1..T+65;
- a second i_start at T+10 is ignored.
- i_valid during QUANT updates the new run_max without changing the active snap_max.
REQ-032 i_rst at T+20 -> no writes after T+20; after release, state ACCUM and run_max = 0.

Source files
------------

// File: rtl/vsq_pkg.sv
// Shared definitions for the VSQ quantizer: FSM encoding, per-QBITS scale
// constants and the saturating absolute value used by the lane max tracking.
package vsq_pkg;

    // FSM encoding
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_QUANT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Largest positive quantized code for a signed QBITS-wide output
    function automatic int qmax_f(input int qbits);
        return (1 << (qbits - 1)) - 1;
    endfunction

    // round(2^16 / QMAX): fixed-point reciprocal used to turn max into scale
    function automatic int recip_f(input int qbits);
        int qm;
        qm = qmax_f(qbits);
        return (65536 + qm / 2) / qm;
    endfunction

    // |x| for a w-bit signed value sign-extended to 64 bits; the most-negative
    // value saturates to 2^(w-1)-1 so the result always fits w bits signed.
    function automatic logic [63:0] abs_sat(input logic [63:0] x, input int w);
        logic [63:0] lim;
        logic [63:0] mag;
        lim = (64'd1 << (w - 1)) - 64'd1;
        mag = x[63] ? (~x + 64'd1) : x;
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/vsq_lane_quant.sv
// One quantizer lane: tracks the running |max| of its input stream, snapshots
// it when a block starts, and quantizes buffer data against that snapshot.
// Rounding mode: VSQ_QUANT_ROUND_EN defined -> round half away from zero,
// otherwise truncate toward zero.
module vsq_lane_quant
    import vsq_pkg::*;
#(
    parameter int DW    = 40,
    parameter int QBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [DW-1:0]    data,
    input  logic             snap,
    input  logic [DW-1:0]    buf_data,
    input  logic             wr,
    output logic [QBITS-1:0] q,
    output logic [DW-1:0]    sf
);

    // Quotient width: |x|*QMAX plus one bit of headroom for the rounding doubling
    localparam int NW = DW + QBITS + 1;
    localparam int SW = DW + 16;
    localparam logic [NW-1:0] QMAX_W  = NW'(qmax_f(QBITS));
    localparam logic [SW-1:0] RECIP_W = SW'(recip_f(QBITS));

    logic [DW-1:0] run_max;
    logic [DW-1:0] snap_max;
    logic [DW-1:0] abs_in;

    assign abs_in = DW'(abs_sat(64'(signed'(data)), DW));

    // Running max; on snap the old max is frozen and tracking restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            run_max  <= '0;
            snap_max <= '0;
        end else if (snap) begin
            snap_max <= run_max;
            run_max  <= valid ? abs_in : '0;
        end else if (valid && (abs_in > run_max)) begin
            run_max <= abs_in;
        end
    end

    logic          neg;
    logic [DW-1:0] mag;
    logic [NW-1:0] num;
    logic [NW-1:0] den;
    logic [NW-1:0] quo;
    logic [NW-1:0] qa;
    logic [SW-1:0] sf_prod;

    // Sign-magnitude divide: |x|*QMAX/m, clamp, then reapply the sign.
    // Magnitude of the most-negative x is 2^(DW-1), still exact in DW bits unsigned.
    always_comb begin
        neg = buf_data[DW-1];
        mag = neg ? (~buf_data + DW'(1)) : buf_data;
        num = NW'(mag) * QMAX_W;
`ifdef VSQ_QUANT_ROUND_EN
        num = (num << 1) + NW'(snap_max);
        den = NW'(snap_max) << 1;
`else
        den = NW'(snap_max);
`endif
        quo     = (snap_max == '0) ? '0 : num / den;
        qa      = (quo > QMAX_W) ? QMAX_W : quo;
        sf_prod = SW'(snap_max) * RECIP_W;
        q  = '0;
        sf = '0;
        if (wr) begin
            q  = neg ? QBITS'(-qa) : QBITS'(qa);
            sf = DW'(sf_prod >> 16);
        end
    end

endmodule

// File: rtl/vsq_quantizer.sv
// Vector scaled quantizer: accumulates per-lane |max| of a streamed vector
// sequence, then on i_start walks a DEPTH-entry buffer and writes each vector
// quantized to QBITS per lane together with the per-lane scale factor.
// Optional macro VSQ_QUANT_ROUND_EN selects round-half-away-from-zero
// (default truncation toward zero).
module vsq_quantizer
    import vsq_pkg::*;
#(
    parameter int NCH   = 16,
    parameter int DW    = 40,
    parameter int FRAC  = 10,
    parameter int QBITS = 4,
    parameter int DEPTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [NCH*DW-1:0]          i_data,
    input  logic                       i_start,
    output logic [$clog2(DEPTH)-1:0]   o_buf_addr,
    input  logic [NCH*DW-1:0]          i_buf_data,
    output logic                       o_ram_we,
    output logic [$clog2(DEPTH)-1:0]   o_ram_addr,
    output logic [NCH*QBITS-1:0]       o_ram_data,
    output logic                       o_sf_valid,
    output logic [NCH*DW-1:0]          o_sf_data,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int AW = $clog2(DEPTH);

    // Data and scale share the same FRAC, so it cancels in x/m; only sanity-check it
    if (FRAC < 0 || FRAC >= DW) begin : g_bad_frac
        $error("vsq_quantizer: FRAC must be in [0, DW)");
    end

    logic [1:0]    state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] waddr_q;
    logic          we_q;
    logic          snap;
    logic          wr;

    assign snap = (state == ST_ACCUM) && i_start;
    // Outputs are forced quiet while reset is held, even before the reset edge
    assign wr   = we_q && !i_rst;

    // Block sequencer and one-stage write pipeline matching the buffer read latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_ACCUM;
            cnt     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            we_q    <= (state == ST_QUANT);
            waddr_q <= cnt;
            case (state)
                ST_ACCUM: begin
                    if (i_start) begin
                        state <= ST_QUANT;
                        cnt   <= '0;
                    end
                end
                ST_QUANT: begin
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= ST_FLUSH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_FLUSH: state <= ST_ACCUM;
                default:  state <= ST_ACCUM;
            endcase
        end
    end

    assign o_buf_addr = ((state == ST_QUANT) && !i_rst) ? cnt : '0;
    assign o_busy     = (state != ST_ACCUM) && !i_rst;
    assign o_ram_we   = wr;
    assign o_sf_valid = wr;
    assign o_ram_addr = wr ? waddr_q : '0;
    assign o_done     = wr && (waddr_q == AW'(DEPTH - 1));

    for (genvar n = 0; n < NCH; n++) begin : g_lane
        vsq_lane_quant #(
            .DW    (DW),
            .QBITS (QBITS)
        ) u_lane (
            .clk      (i_clk),
            .rst      (i_rst),
            .valid    (i_valid),
            .data     (i_data[n*DW +: DW]),
            .snap     (snap),
            .buf_data (i_buf_data[n*DW +: DW]),
            .wr       (wr),
            .q        (o_ram_data[n*QBITS +: QBITS]),
            .sf       (o_sf_data[n*DW +: DW])
        );
    end

endmodule

// File: tb/tb_vsq_quantizer.sv
// Self-checking bench for vsq_quantizer: fixed table vectors on lane 0,
// randomized data on all lanes against a real-arithmetic reference model,
// plus block timing, ignored re-start, mid-block valid and mid-block reset.
module tb_vsq_quantizer;

    localparam int NCH   = 16;
    localparam int DW    = 40;
    localparam int FRAC  = 10;
    localparam int QBITS = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int QMAX  = 7;
    localparam int VW    = NCH * DW;
    localparam int NT    = 10;
    localparam longint MAXPOS = (64'sd1 <<< (DW - 1)) - 1;
`ifdef VSQ_QUANT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef logic [VW-1:0] wide_t;
    typedef struct {
        longint x;
        int     q;
    } tvec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid;
    logic [VW-1:0]        data;
    logic                 start;
    logic [AW-1:0]        buf_addr;
    logic [VW-1:0]        buf_data;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [NCH*QBITS-1:0] ram_data;
    logic                 sf_valid;
    logic [VW-1:0]        sf_data;
    logic                 busy;
    logic                 done;

    vsq_quantizer #(.NCH(NCH), .DW(DW), .FRAC(FRAC), .QBITS(QBITS), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_start(start),
        .o_buf_addr(buf_addr), .i_buf_data(buf_data), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_sf_valid(sf_valid),
        .o_sf_data(sf_data), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffer model
    logic [VW-1:0] mem [DEPTH];
    always @(posedge clk) buf_data <= mem[buf_addr];

    int     checks = 0;
    int     errors = 0;
    longint model_run  [NCH];
    longint model_snap [NCH];
    tvec_t  tbl [NT];

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint lane_of(input wide_t v, input int n);
        logic signed [DW-1:0] t;
        t = v[n*DW +: DW];
        return longint'(t);
    endfunction

    function automatic longint absat(input longint x);
        longint a;
        a = (x < 0) ? -x : x;
        return (a > MAXPOS) ? MAXPOS : a;
    endfunction

    // q = x*QMAX/m in real arithmetic, rounded per build mode, clamped
    function automatic longint ref_q(input longint x, input longint m);
        real r;
        if (m == 0) return 0;
        r = real'(x) * QMAX / real'(m);
        if (r >= QMAX) return QMAX;
        if (r <= -QMAX) return -QMAX;
        if (RND) return (r < 0.0) ? -longint'($rtoi(-r + 0.5)) : longint'($rtoi(r + 0.5));
        return longint'($rtoi(r));
    endfunction

    function automatic longint ref_sf(input longint m);
        longint recip;
        recip = longint'($rtoi(65536.0 / QMAX + 0.5));
        return (m * recip) >>> 16;
    endfunction

    function automatic wide_t rand_vec();
        wide_t  v;
        longint r;
        for (int n = 0; n < NCH; n++) begin
            r = longint'(signed'($urandom)) >>> $urandom_range(0, 24);
            v[n*DW +: DW] = DW'(r);
        end
        return v;
    endfunction

    function automatic void model_accum(input wide_t v);
        for (int n = 0; n < NCH; n++)
            if (absat(lane_of(v, n)) > model_run[n]) model_run[n] = absat(lane_of(v, n));
    endfunction

    task automatic feed(input wide_t v);
        valid = 1'b1;
        data  = v;
        model_accum(v);
        step();
        valid = 1'b0;
    endtask

    task automatic start_block(input bit with_valid);
        start = 1'b1;
        valid = with_valid;
        data  = rand_vec();
        for (int n = 0; n < NCH; n++) begin
            model_snap[n] = model_run[n];
            model_run[n]  = with_valid ? absat(lane_of(data, n)) : 0;
        end
        step();
        start = 1'b0;
        valid = 1'b0;
    endtask

    // Observes a block from the cycle after the start edge (rel 0)
    task automatic run_block(input bit use_tbl, input int rst_at);
        bit                   aborted;
        bit                   we_e;
        int                   a;
        logic [NCH*QBITS-1:0] eq;
        wide_t                es;
        logic signed [QBITS-1:0] q0;
        aborted = 1'b0;
        for (int rel = 0; rel <= 68; rel++) begin
            we_e = !aborted && rel >= 1 && rel <= 64;
            a    = rel - 1;
            chk("busy",     wide_t'(busy),     wide_t'(!aborted && rel <= 64));
            chk("buf_addr", wide_t'(buf_addr), wide_t'((!aborted && rel <= 63) ? rel : 0));
            chk("ram_we",   wide_t'(ram_we),   wide_t'(we_e));
            chk("sf_valid", wide_t'(sf_valid), wide_t'(we_e));
            chk("ram_addr", wide_t'(ram_addr), wide_t'(we_e ? a : 0));
            chk("done",     wide_t'(done),     wide_t'(we_e && a == DEPTH - 1));
            eq = '0;
            es = '0;
            if (we_e) begin
                for (int n = 0; n < NCH; n++) begin
                    eq[n*QBITS +: QBITS] = QBITS'(ref_q(lane_of(mem[a], n), model_snap[n]));
                    es[n*DW +: DW]       = DW'(ref_sf(model_snap[n]));
                end
            end
            chk("ram_data", wide_t'(ram_data), wide_t'(eq));
            chk("sf_data",  sf_data, es);
            if (we_e && use_tbl && a < NT) begin
                q0 = ram_data[QBITS-1:0];
                chk("tbl_q", wide_t'(longint'(q0)), wide_t'(longint'(tbl[a].q)));
            end
            if (we_e && use_tbl && a == 0) begin
                chk("sf_lane0", wide_t'(sf_data[DW-1:0]), wide_t'(1023));
                chk("sf_lane2_sat", wide_t'(sf_data[2*DW +: DW]),
                    wide_t'(((longint'(1) <<< 39) - 1) * 9362 >>> 16));
            end
            // Inputs for the next edge
            start = (rel == 8);
            valid = (rel == 19);
            if (valid) begin
                data = rand_vec();
                model_accum(data);
            end
            if (rel == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", wide_t'(busy),     '0);
                chk("rst_we",   wide_t'(ram_we),   '0);
                chk("rst_addr", wide_t'(buf_addr), '0);
                chk("rst_data", wide_t'(ram_data), '0);
                chk("rst_sf",   sf_data,           '0);
                chk("rst_done", wide_t'(done),     '0);
                aborted = 1'b1;
                for (int n = 0; n < NCH; n++) model_run[n] = 0;
            end
            step();
            rst = 1'b0;
        end
        start = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        wide_t v;
        tbl[0] = '{3072, 3};
        tbl[1] = '{-7168, -7};
        tbl[2] = '{1536, RND ? 2 : 1};
        tbl[3] = '{20480, 7};
        tbl[4] = '{-20480, -7};
        tbl[5] = '{0, 0};
        tbl[6] = '{7168, 7};
        tbl[7] = '{-1536, RND ? -2 : -1};
        tbl[8] = '{1024, 1};
        tbl[9] = '{512, RND ? 1 : 0};

        for (int n = 0; n < NCH; n++) begin
            model_run[n]  = 0;
            model_snap[n] = 0;
        end
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;

        // Reset held with active inputs: everything must stay quiet
        rst   = 1'b1;
        valid = 1'b1;
        start = 1'b1;
        data  = rand_vec();
        step();
        step();
        chk("reset_busy",     wide_t'(busy),     '0);
        chk("reset_buf_addr", wide_t'(buf_addr), '0);
        chk("reset_we",       wide_t'(ram_we),   '0);
        chk("reset_ram_addr", wide_t'(ram_addr), '0);
        chk("reset_ram_data", wide_t'(ram_data), '0);
        chk("reset_sf_valid", wide_t'(sf_valid), '0);
        chk("reset_sf_data",  sf_data,           '0);
        chk("reset_done",     wide_t'(done),     '0);
        rst   = 1'b0;
        valid = 1'b0;
        start = 1'b0;
        step();

        // Accumulate: lane0 max 7.0, lane1 never non-zero, lane2 most-negative
        v = rand_vec();
        v[0*DW +: DW] = DW'(7168);
        v[1*DW +: DW] = '0;
        v[2*DW +: DW] = DW'(-(longint'(1) <<< 39));
        feed(v);
        for (int k = 0; k < 4; k++) begin
            v = rand_vec();
            v[0*DW +: DW] = DW'(longint'($urandom_range(0, 14336)) - 7168);
            v[1*DW +: DW] = '0;
            feed(v);
        end

        for (int a = 0; a < DEPTH; a++) begin
            v = rand_vec();
            v[0*DW +: DW] = (a < NT) ? DW'(tbl[a].x)
                                     : DW'(longint'($urandom_range(0, 43008)) - 21504);
            mem[a] = v;
        end

        // Block A: table + random, re-start ignored, valid mid-block
        start_block(1'b1);
        run_block(1'b1, -1);

        // Block B: snapshot from start vector and mid-block vector, reset mid-QUANT
        for (int a = 0; a < DEPTH; a++) mem[a] = rand_vec();
        start_block(1'b1);
        run_block(1'b0, 20);

        // Block C: run_max cleared by reset -> all scales and codes zero
        start_block(1'b0);
        run_block(1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
